mmio_io_bridge: RTL and testbench
=================================

# mmio_io_bridge

Parametrised memory-mapped I/O bridge between the processor data port and the data RAM. It decodes a 64-word I/O window starting at `BASE_ADDR` and diverts accesses there away from the RAM. Inside the window it provides `N_IN` synchronised, debounced input channels with sticky rising-edge flags, `N_OUT` read/write output registers, and a free-running cycle counter. It generalises the single switch-in/LED-out decode, which has fixed addresses, one channel each way and no debounce or edge capture.

## Interface
Parameters:
- `BASE_ADDR`, 4096: word address of the window start; the window spans `BASE_ADDR`..`BASE_ADDR+63`.
- `N_IN`, 1: number of input channels, 1..16.
- `N_OUT`, 1: number of output channels, 1..16.
- `W`, 16: channel width in bits, 1..32.
- `DEBOUNCE`, 0: number of stable cycles required before a new input value is accepted. 0 bypasses debounce.
- `OUT_RESET`, 0: reset value of every output register.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock; all logic runs on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `address_dmem`  in  32  processor data address.
- `wren`  in  1  processor write enable.
- `data`  in  32  processor write data.
- `q_dmem`  out  32  read data returned to the processor.
- `ram_wren`  out  1  RAM write enable, equal to `wren & ~io_hit`.
- `ram_q`  in  32  RAM read data.
- `io_in`  in  `N_IN*W`  asynchronous input pins; channel i is bits `[i*W +: W]`.
- `io_out`  out  `N_OUT*W`  output registers, driven directly from flops.

## Operation
Address decode: `io_hit` is asserted when `address_dmem - BASE_ADDR` is less than 64. The offset is `address_dmem - BASE_ADDR`, 6 bits.

Register map by offset:
- 0x00+i: `IN[i]`, read-only debounced value, zero-extended to 32 bits.
- 0x10+j: `OUT[j]`, read/write. A write stores `data[W-1:0]`.
- 0x20+i: `EDGE[i]`, sticky rising-edge flags. Writing 1 to a bit clears that bit (write-1-to-clear).
- 0x30: `CYCLES`, 32-bit counter. Reads return the count. Any write clears it to 0.
- 0x31: `ID`, read-only `{8'hA5, N_IN[3:0], N_OUT[3:0], 16'(W)}`.
- Unmapped offsets, or channel indices ≥ `N_IN`/`N_OUT`: read 0, writes ignored.

Write behaviour:
- Writes inside the window never reach the RAM.
- Writes outside the window pass through to the RAM.

Input channel pipeline:
- Two-flop synchroniser.
- Debounce: a counter resets whenever the synchronised value differs from the candidate. When the candidate has been stable for `DEBOUNCE` consecutive cycles, it is accepted into `IN[i]`. With `DEBOUNCE = 0`, `IN[i]` is the synchroniser output delayed by one flop.
- Edge capture: `EDGE[i]` is set by `IN[i] & ~IN_prev[i]`.

Counter: `CYCLES` increments every cycle and wraps from 0xFFFFFFFF to 0.

Simultaneous events:
- A new edge and a W1C write on the same bit in the same cycle: the set wins, and the bit reads 1.
- A `CYCLES` write and an increment in the same cycle: the write wins, and the next value read is 1 cycle later, i.e. 0 then 1.

Reset:
- Synchroniser, debounce counters, `IN`, `EDGE`, and `CYCLES` go to 0.
- `io_out` goes to `OUT_RESET`.
- The read-select and read-data registers go to 0, so `q_dmem = ram_q` on the first cycle after reset.
- A reset mid-debounce discards the candidate.

## Timing
- Read latency is 1 cycle, matching the synchronous RAM. On each edge the bridge registers `io_hit` and the I/O read data. `q_dmem` equals the registered data when the registered hit is 1, and `ram_q` otherwise.
- An `OUT[j]` write is visible on `io_out` 1 cycle after the write edge. A read at the same address in the following cycle returns the new value.
- Pin-to-`IN` latency is 3 cycles with `DEBOUNCE = 0`, and 3 + `DEBOUNCE` cycles otherwise.
- An `EDGE` bit is set 1 cycle after `IN` rises.
- `ram_wren` is combinational from `wren` and `address_dmem`.

## Structure
- Package `mmio_pkg`: offset constants `OFF_IN`, `OFF_OUT`, `OFF_EDGE`, `OFF_CYCLES`, `OFF_ID`, the window size 64, and the `ID` tag `8'hA5`.
- Sub-module `mmio_in_channel`, parameters `W` and `DEBOUNCE`: contains the synchroniser, debounce and edge-flag logic, and takes a W1C mask input. It is instantiated `N_IN` times in a generate loop.
- The top level holds the decode, output registers, counter and read mux.

## Test plan
- Reset with `OUT_RESET=16'h00FF` → `io_out=16'h00FF`, `q_dmem=ram_q`, `CYCLES` reads a small value counted from 0.
- Write `16'hBEEF` to 4097+15 (offset 0x10), `N_OUT=1` → `io_out=16'hBEEF` after 1 cycle, `ram_wren=0`; a read returns `32'h0000BEEF` with 1-cycle latency.
- `DEBOUNCE=4`: toggle `io_in` bit 0 high for 3 cycles, then hold it high → `IN[0]` ignores the glitch and reads 1 exactly 7 cycles after the stable rise.
- `io_in` goes `0→16'h0005` → `EDGE[0]=16'h0005`. Write `16'h0001` to 0x20 in the same cycle as a new bit-0 edge → bit 0 stays 1. A later W1C with `16'h0005` → reads 0.
- Address 4096+0x3F: read returns 0, write does not reach the RAM. Address 5000: `ram_wren=wren`, `q_dmem=ram_q`.
- Write to `CYCLES` → the next read returns 0 or 1 per the rule above. Preload near 0xFFFFFFFF in simulation (force) → wraps to 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - register map constants for the memory-mapped I/O window
package mmio_pkg;

  localparam int         WINDOW_WORDS = 64;
  localparam logic [5:0] OFF_IN       = 6'h00;
  localparam logic [5:0] OFF_OUT      = 6'h10;
  localparam logic [5:0] OFF_EDGE     = 6'h20;
  localparam logic [5:0] OFF_CYCLES   = 6'h30;
  localparam logic [5:0] OFF_ID       = 6'h31;
  localparam logic [7:0] ID_TAG       = 8'hA5;

  // The upper two offset bits select a 16-word bank of the window.
  typedef enum logic [1:0] {
    BANK_IN   = 2'd0,
    BANK_OUT  = 2'd1,
    BANK_EDGE = 2'd2,
    BANK_MISC = 2'd3
  } bank_e;

endpackage

// File: rtl/mmio_in_channel.sv
// rtl/mmio_in_channel.sv - one input channel: synchroniser, debounce, sticky rising-edge flags
module mmio_in_channel #(
  parameter int W        = 16,
  parameter int DEBOUNCE = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] pin,
  input  logic [W-1:0] w1c,
  output logic [W-1:0] value,
  output logic [W-1:0] edges
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] in_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  if (DEBOUNCE == 0) begin : g_bypass
    always_ff @(posedge clock) begin
      if (reset) value <= '0;
      else       value <= sync2;
    end
  end else begin : g_debounce
    localparam int CW = $clog2(DEBOUNCE + 1);
    logic [W-1:0]  cand;
    logic [CW-1:0] cnt;

    // Any change restarts the count; acceptance happens once, on the cycle the
    // candidate has matched the synchroniser for DEBOUNCE further samples.
    always_ff @(posedge clock) begin
      if (reset) begin
        cand  <= '0;
        cnt   <= '0;
        value <= '0;
      end else if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else begin
        if (cnt != CW'(DEBOUNCE))     cnt   <= cnt + 1'b1;
        if (cnt == CW'(DEBOUNCE - 1)) value <= cand;
      end
    end
  end

  // Set is applied after the clear so a coincident edge survives the W1C.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_prev <= '0;
      edges   <= '0;
    end else begin
      in_prev <= value;
      edges   <= (edges & ~w1c) | (value & ~in_prev);
    end
  end

endmodule

// File: rtl/mmio_io_bridge.sv
// rtl/mmio_io_bridge.sv - memory-mapped I/O window in front of the data RAM
module mmio_io_bridge
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd4096,
  parameter int          N_IN      = 1,
  parameter int          N_OUT     = 1,
  parameter int          W         = 16,
  parameter int          DEBOUNCE  = 0,
  parameter logic [W-1:0] OUT_RESET = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        address_dmem,
  input  logic               wren,
  input  logic [31:0]        data,
  output logic [31:0]        q_dmem,
  output logic               ram_wren,
  input  logic [31:0]        ram_q,
  input  logic [N_IN*W-1:0]  io_in,
  output logic [N_OUT*W-1:0] io_out
);

  logic [31:0] offset_full;
  logic [5:0]  offset;
  logic [3:0]  idx;
  bank_e       bank;
  logic        io_hit;
  logic        io_wr;

  // Unsigned subtraction makes addresses below the base wrap high and miss.
  assign offset_full = address_dmem - BASE_ADDR;
  assign io_hit      = offset_full < 32'(WINDOW_WORDS);
  assign offset      = offset_full[5:0];
  assign idx         = offset[3:0];
  assign bank        = bank_e'(offset[5:4]);
  assign io_wr       = wren & io_hit;
  assign ram_wren    = wren & ~io_hit;

  logic [W-1:0] in_val   [N_IN];
  logic [W-1:0] edge_val [N_IN];
  logic [W-1:0] out_reg  [N_OUT];
  logic [31:0]  cycle_count;
  logic [31:0]  rd_mux;
  logic [31:0]  rdata_q;
  logic         hit_q;
  logic         unused_data;

  assign unused_data = ^data;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    logic [W-1:0] w1c;
    assign w1c = (io_wr && bank == BANK_EDGE && idx == 4'(i)) ? data[W-1:0] : '0;

    mmio_in_channel #(.W(W), .DEBOUNCE(DEBOUNCE)) u_channel (
      .clock (clock),
      .reset (reset),
      .pin   (io_in[i*W +: W]),
      .w1c   (w1c),
      .value (in_val[i]),
      .edges (edge_val[i])
    );
  end

  always_ff @(posedge clock) begin
    for (int j = 0; j < N_OUT; j++) begin
      if (reset)                                             out_reg[j] <= OUT_RESET;
      else if (io_wr && bank == BANK_OUT && idx == 4'(j))    out_reg[j] <= data[W-1:0];
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    assign io_out[j*W +: W] = out_reg[j];
  end

  always_ff @(posedge clock) begin
    if (reset)                               cycle_count <= '0;
    else if (io_wr && offset == OFF_CYCLES)  cycle_count <= '0;
    else                                     cycle_count <= cycle_count + 32'd1;
  end

  always_comb begin
    rd_mux = '0;
    case (bank)
      BANK_IN:   for (int i = 0; i < N_IN; i++)  if (idx == 4'(i)) rd_mux = 32'(in_val[i]);
      BANK_OUT:  for (int j = 0; j < N_OUT; j++) if (idx == 4'(j)) rd_mux = 32'(out_reg[j]);
      BANK_EDGE: for (int i = 0; i < N_IN; i++)  if (idx == 4'(i)) rd_mux = 32'(edge_val[i]);
      BANK_MISC: begin
        if (offset == OFF_CYCLES)  rd_mux = cycle_count;
        else if (offset == OFF_ID) rd_mux = {ID_TAG, 4'(N_IN), 4'(N_OUT), 16'(W)};
      end
    endcase
  end

  // Registered alongside the synchronous RAM so both paths share one cycle of latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      hit_q   <= io_hit;
      rdata_q <= rd_mux;
    end
  end

  assign q_dmem = hit_q ? rdata_q : ram_q;

endmodule

// File: tb/tb_mmio_io_bridge.sv
// tb/tb_mmio_io_bridge.sv - randomized and directed bench for mmio_io_bridge
module tb_mmio_io_bridge;
  import mmio_pkg::*;

  localparam logic [31:0] BASE   = 32'd4096;
  localparam int          NI     = 2;
  localparam int          NO     = 2;
  localparam int          W      = 16;
  localparam int          DEB    = 4;
  localparam logic [15:0] ORST   = 16'h00FF;
  localparam int          HIST   = DEB + 3;
  localparam logic [31:0] ID_EXP = 32'hA522_0010;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [31:0]    address_dmem = '0;
  logic           wren = 1'b0;
  logic [31:0]    data = '0;
  logic [31:0]    q_dmem;
  logic           ram_wren;
  logic [31:0]    ram_q = '0;
  logic [NI*W-1:0] io_in = '0;
  logic [NO*W-1:0] io_out;

  int errors = 0;
  int checks = 0;
  logic [NI*W-1:0] cur = '0;

  always #5 clock = ~clock;

  mmio_io_bridge #(
    .BASE_ADDR(BASE), .N_IN(NI), .N_OUT(NO), .W(W), .DEBOUNCE(DEB), .OUT_RESET(ORST)
  ) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .wren(wren), .data(data),
    .q_dmem(q_dmem), .ram_wren(ram_wren), .ram_q(ram_q), .io_in(io_in), .io_out(io_out)
  );

  // Reference model: pin history per channel; IN takes a value once it has been
  // seen unchanged over DEBOUNCE+1 consecutive synchronised samples.
  logic [W-1:0] m_out  [NO];
  logic [W-1:0] m_edge [NI];
  logic [W-1:0] m_in   [NI];
  logic [W-1:0] m_in_prev [NI];
  logic [W-1:0] m_hist [NI][HIST];
  logic [31:0]  m_cycles = '0;
  logic [31:0]  m_rdata_q = '0;
  logic         m_hit_q = 1'b0;
  logic         m_ram_wren = 1'b0;

  function automatic logic [31:0] win(input int off);
    return BASE + 32'(off);
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] o);
    int k;
    logic [31:0] v;
    v = '0;
    k = int'(o[3:0]);
    if (o[5:4] == 2'd0 && k < NI) v = {16'h0, m_in[k]};
    if (o[5:4] == 2'd1 && k < NO) v = {16'h0, m_out[k]};
    if (o[5:4] == 2'd2 && k < NI) v = {16'h0, m_edge[k]};
    if (o == 6'h30) v = m_cycles;
    if (o == 6'h31) v = ID_EXP;
    return v;
  endfunction

  function automatic logic [NO*W-1:0] model_out_bus();
    logic [NO*W-1:0] v;
    for (int j = 0; j < NO; j++) v[j*W +: W] = m_out[j];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NI; c++) begin
      m_edge[c] = '0; m_in[c] = '0; m_in_prev[c] = '0;
      for (int k = 0; k < HIST; k++) m_hist[c][k] = '0;
    end
    for (int j = 0; j < NO; j++) m_out[j] = ORST;
    m_cycles = '0; m_rdata_q = '0; m_hit_q = 1'b0;
  endtask

  task automatic model_clock(input logic [31:0] a, input logic wr, input logic [31:0] d,
                             input logic [NI*W-1:0] p);
    logic [31:0] off;
    logic hit, stable;
    logic [5:0] o;
    logic [W-1:0] nxt, clr;
    off = a - BASE;
    hit = off < 32'd64;
    o = off[5:0];
    m_ram_wren = wr && !hit;
    if (reset) begin
      model_reset();
    end else begin
      m_rdata_q = model_read(o);
      m_hit_q = hit;
      for (int c = 0; c < NI; c++) begin
        for (int k = HIST - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[c][0] = p[c*W +: W];
        stable = 1'b1;
        for (int k = 2; k < HIST; k++) if (m_hist[c][k] != m_hist[c][2]) stable = 1'b0;
        nxt = stable ? m_hist[c][2] : m_in[c];
        clr = (wr && hit && o == 6'(32 + c)) ? d[W-1:0] : '0;
        m_edge[c] = (m_edge[c] & ~clr) | (m_in[c] & ~m_in_prev[c]);
        m_in_prev[c] = m_in[c];
        m_in[c] = nxt;
      end
      for (int j = 0; j < NO; j++) if (wr && hit && o == 6'(16 + j)) m_out[j] = d[W-1:0];
      if (wr && hit && o == OFF_CYCLES) m_cycles = '0;
      else m_cycles = m_cycles + 32'd1;
    end
  endtask

  task automatic step(input logic [31:0] a, input logic wr, input logic [31:0] d);
    address_dmem = a; wren = wr; data = d; io_in = cur; ram_q = $urandom;
    @(posedge clock);
    model_clock(a, wr, d, cur);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(32'd0, 1'b0, 32'd0);
    step(32'd0, 1'b0, 32'd0);
    reset = 1'b0;
    checks++; if (io_out !== {ORST, ORST}) begin errors++; $display("FAIL reset_io_out: got %h want %h", io_out, {ORST, ORST}); end
    checks++; if (q_dmem !== ram_q) begin errors++; $display("FAIL reset_q_is_ram: got %h want %h", q_dmem, ram_q); end
    step(win(48), 1'b0, 32'd0);
    checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL reset_cycles0: got %h want 0", q_dmem); end
    step(win(48), 1'b0, 32'd0);
    checks++; if (q_dmem !== 32'd1) begin errors++; $display("FAIL reset_cycles1: got %h want 1", q_dmem); end
  endtask

  task automatic test_out_write();
    step(win(16), 1'b1, 32'h1234_BEEF);
    checks++; if (io_out !== {ORST, 16'hBEEF}) begin errors++; $display("FAIL out_write_pins: got %h want %h", io_out, {ORST, 16'hBEEF}); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL out_write_ram_wren: got %b want 0", ram_wren); end
    step(win(16), 1'b0, 32'd0);
    checks++; if (q_dmem !== 32'h0000_BEEF) begin errors++; $display("FAIL out_readback: got %h want 0000beef", q_dmem); end
    step(win(17), 1'b1, 32'h0000_5A5A);
    step(win(18), 1'b1, 32'h0000_FFFF);
    checks++; if (io_out !== model_out_bus() || io_out !== 32'h5A5A_BEEF) begin errors++; $display("FAIL out_second_chan: got %h want 5a5abeef", io_out); end
    step(win(18), 1'b0, 32'd0);
    checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL out_unmapped_idx: got %h want 0", q_dmem); end
  endtask

  task automatic test_debounce();
    int first;
    logic [31:0] exp_q;
    logic glitch_seen;
    glitch_seen = 1'b0;
    cur = '0;
    for (int i = 0; i < 9; i++) begin
      cur[0] = (i < 3);
      step(win(0), 1'b0, 32'd0);
      if (q_dmem !== 32'd0) glitch_seen = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      step(win(0), 1'b0, 32'd0);
      if (q_dmem !== 32'd0) glitch_seen = 1'b1;
    end
    checks++; if (glitch_seen) begin errors++; $display("FAIL debounce_glitch: got 1 want 0"); end
    first = -1;
    cur[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(win(0), 1'b0, 32'd0);
      exp_q = m_hit_q ? m_rdata_q : ram_q;
      checks++; if (q_dmem !== exp_q) begin errors++; $display("FAIL debounce_model[%0d]: got %h want %h", i, q_dmem, exp_q); end
      if (first < 0 && q_dmem === 32'd1) first = i;
    end
    checks++; if (first != 3 + DEB) begin errors++; $display("FAIL debounce_latency: got %0d want %0d", first, 3 + DEB); end
  endtask

  task automatic test_edge();
    cur = '0;
    for (int i = 0; i < 10; i++) step(win(32), 1'b0, 32'd0);
    step(win(32), 1'b1, 32'h0000_FFFF);
    step(win(32), 1'b0, 32'd0);
    checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL edge_clear_all: got %h want 0", q_dmem); end
    cur = 32'h0000_0005;
    for (int i = 0; i < 10; i++) step(win(32), 1'b0, 32'd0);
    checks++; if (q_dmem !== 32'h5) begin errors++; $display("FAIL edge_rise5: got %h want 5", q_dmem); end
    cur = 32'h0000_0004;
    for (int i = 0; i < 10; i++) step(win(32), 1'b0, 32'd0);
    step(win(32), 1'b1, 32'h0000_0001);
    step(win(32), 1'b0, 32'd0);
    checks++; if (q_dmem !== 32'h4) begin errors++; $display("FAIL edge_w1c_bit0: got %h want 4", q_dmem); end
    cur = 32'h0000_0005;
    for (int i = 0; i < 7; i++) step(win(32), 1'b0, 32'd0);
    step(win(32), 1'b1, 32'h0000_0001);
    step(win(32), 1'b0, 32'd0);
    checks++; if (q_dmem !== 32'h5 || m_rdata_q !== 32'h5) begin errors++; $display("FAIL edge_set_wins: got %h want 5", q_dmem); end
    step(win(32), 1'b1, 32'h0000_0005);
    step(win(32), 1'b0, 32'd0);
    checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL edge_w1c_all: got %h want 0", q_dmem); end
  endtask

  task automatic test_decode();
    step(win(63), 1'b1, 32'hDEAD_BEEF);
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL decode_top_wren: got %b want 0", ram_wren); end
    step(win(63), 1'b0, 32'd0);
    checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL decode_top_read: got %h want 0", q_dmem); end
    step(win(49), 1'b0, 32'd0);
    checks++; if (q_dmem !== ID_EXP) begin errors++; $display("FAIL decode_id: got %h want %h", q_dmem, ID_EXP); end
    step(32'd5000, 1'b1, 32'h1111_2222);
    checks++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL decode_5000_wren: got %b want 1", ram_wren); end
    step(32'd5000, 1'b0, 32'd0);
    checks++; if (q_dmem !== ram_q || ram_wren !== 1'b0) begin errors++; $display("FAIL decode_5000_read: got %h want %h", q_dmem, ram_q); end
    step(BASE - 32'd1, 1'b1, 32'd0);
    checks++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL decode_below_base: got %b want 1", ram_wren); end
    step(win(64), 1'b1, 32'd0);
    checks++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL decode_above_top: got %b want 1", ram_wren); end
  endtask

  task automatic test_cycles();
    logic [31:0] prev;
    logic steps_ok, seen_wrap;
    step(win(48), 1'b1, 32'hFFFF_FFFF);
    step(win(48), 1'b0, 32'd0);
    checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL cycles_after_write0: got %h want 0", q_dmem); end
    step(win(48), 1'b0, 32'd0);
    checks++; if (q_dmem !== 32'd1) begin errors++; $display("FAIL cycles_after_write1: got %h want 1", q_dmem); end
    force dut.cycle_count = 32'hFFFF_FFF8;
    step(win(48), 1'b0, 32'd0);
    release dut.cycle_count;
    step(win(48), 1'b0, 32'd0);
    prev = q_dmem;
    steps_ok = 1'b1;
    seen_wrap = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(win(48), 1'b0, 32'd0);
      if (q_dmem !== prev + 32'd1) steps_ok = 1'b0;
      if (prev === 32'hFFFF_FFFF && q_dmem === 32'd0) seen_wrap = 1'b1;
      prev = q_dmem;
    end
    checks++; if (!steps_ok) begin errors++; $display("FAIL cycles_increment: got nonconsecutive want consecutive"); end
    checks++; if (!seen_wrap) begin errors++; $display("FAIL cycles_wrap: got no wrap want ffffffff->0"); end
    step(win(48), 1'b1, 32'd0);
  endtask

  task automatic test_random();
    logic [31:0] a, exp_q;
    logic wr;
    int sel;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) cur = $urandom;
      reset = ($urandom_range(0, 99) == 0);
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1:    a = win(int'($urandom_range(0, 3)));
        2, 3:    a = win(16 + int'($urandom_range(0, 3)));
        4, 5:    a = win(32 + int'($urandom_range(0, 3)));
        6:       a = win(48 + int'($urandom_range(0, 2)));
        7:       a = win(int'($urandom_range(0, 63)));
        8:       a = ($urandom_range(0, 1) == 0) ? BASE - 32'd1 : win(64);
        default: a = $urandom;
      endcase
      wr = ($urandom_range(0, 3) == 0);
      step(a, wr, $urandom);
      exp_q = m_hit_q ? m_rdata_q : ram_q;
      checks++; if (q_dmem !== exp_q) begin errors++; $display("FAIL rand_q[%0d]: got %h want %h", n, q_dmem, exp_q); end
      checks++; if (io_out !== model_out_bus()) begin errors++; $display("FAIL rand_io_out[%0d]: got %h want %h", n, io_out, model_out_bus()); end
      checks++; if (ram_wren !== m_ram_wren) begin errors++; $display("FAIL rand_ram_wren[%0d]: got %b want %b", n, ram_wren, m_ram_wren); end
    end
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_out_write();
    test_debounce();
    test_edge();
    test_decode();
    test_cycles();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
